// File: rtl/fp_mul_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe_pkg
// Description : Shared types and helpers for the pipelined FP multiplier:
//               operand classes, exception flag bundle, exponent bias and
//               canonical quiet-NaN pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pipe_pkg;

  // Widest encoding the canonical-NaN helper can build.
  localparam int QNAN_MAX_W = 128;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    NORM = 3'd1,
    INF  = 3'd2,
    QNAN = 3'd3,
    SNAN = 3'd4
  } fp_class_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic inexact;
  } fp_flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, zeros}; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [QNAN_MAX_W-1:0] canonical_qnan(input int exp_w, input int man_w);
    logic [QNAN_MAX_W-1:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) begin
      q[man_w + i] = 1'b1;
    end
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

endpackage : fp_mul_pipe_pkg
`default_nettype wire

// File: rtl/fp_mul_pipe_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp_unpack
// Description : Splits one IEEE-754 operand into sign/exponent/significand,
//               classifies it, and flushes subnormals to signed zero (DAZ).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unpack
  import fp_mul_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output fp_class_t            cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign exp_f  = op_i[EXP_W+MAN_W-1:MAN_W];
  assign frac_f = op_i[MAN_W-1:0];

  // Classify the operand; subnormals fall into ZERO with a cleared significand.
  always_comb begin
    sign_o = op_i[EXP_W+MAN_W];
    exp_o  = exp_f;
    sig_o  = {1'b1, frac_f};
    cls_o  = NORM;
    if (exp_f == {EXP_W{1'b1}}) begin
      sig_o = '0;
      if (frac_f == '0)          cls_o = INF;
      else if (frac_f[MAN_W-1])  cls_o = QNAN;
      else                       cls_o = SNAN;
    end else if (exp_f == '0) begin
      cls_o = ZERO;
      sig_o = '0;
      exp_o = '0;
    end
  end

endmodule : fp_unpack
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : 3-stage pipelined IEEE-754 multiplier (unpack / multiply /
//               normalise-round-pack) with valid/ready handshake, tag
//               passthrough, DAZ/FTZ and IEEE exception flags.
//               Optional macro FP_MUL_PIPE_RNE_EN selects round-to-nearest-
//               even; otherwise the result is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe
  import fp_mul_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_invalid,
  output logic                 out_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = canonical_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]          QNAN_C    = QNAN_FULL[W-1:0];
  localparam logic signed [EW-1:0]  BIAS_C    = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0]  EMAX_C    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  ONE_C     = EW'(1);

  // A single advance enable moves every stage together; a stall freezes all.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_sig, b_sig;
  fp_class_t        a_cls, b_cls;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op_i(in_a), .sign_o(a_sign), .exp_o(a_exp), .sig_o(a_sig), .cls_o(a_cls)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op_i(in_b), .sign_o(b_sign), .exp_o(b_exp), .sig_o(b_sig), .cls_o(b_cls)
  );

  logic signed [EW-1:0] s1_e_d;
  assign s1_e_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_C;

  logic                 s1_valid_q, s1_sign_q;
  fp_class_t            s1_cls_a_q, s1_cls_b_q;
  logic signed [EW-1:0] s1_e_q;
  logic [MAN_W:0]       s1_siga_q, s1_sigb_q;
  logic [TAG_W-1:0]     s1_tag_q;

  // Stage 1 register: classified operands and biased exponent sum.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_a_q <= ZERO;
      s1_cls_b_q <= ZERO;
      s1_e_q     <= '0;
      s1_siga_q  <= '0;
      s1_sigb_q  <= '0;
      s1_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q  <= a_sign ^ b_sign;
        s1_cls_a_q <= a_cls;
        s1_cls_b_q <= b_cls;
        s1_e_q     <= s1_e_d;
        s1_siga_q  <= a_sig;
        s1_sigb_q  <= b_sig;
        s1_tag_q   <= in_tag;
      end
    end
  end

  // ---------------- S2: multiply ----------------
  logic                 s2_valid_q, s2_sign_q;
  fp_class_t            s2_cls_a_q, s2_cls_b_q;
  logic signed [EW-1:0] s2_e_q;
  logic [PW-1:0]        s2_p_q;
  logic [TAG_W-1:0]     s2_tag_q;

  // Stage 2 register: full-width significand product plus carried context.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_cls_a_q <= ZERO;
      s2_cls_b_q <= ZERO;
      s2_e_q     <= '0;
      s2_p_q     <= '0;
      s2_tag_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q  <= s1_sign_q;
        s2_cls_a_q <= s1_cls_a_q;
        s2_cls_b_q <= s1_cls_b_q;
        s2_e_q     <= s1_e_q;
        s2_p_q     <= s1_siga_q * s1_sigb_q;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic                 p_msb, guard, sticky, round_up;
  logic [MAN_W-1:0]     frac_raw;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] e_norm, e_fin;
  logic                 nan_any, snan_any, inf_a, inf_b, zero_a, zero_b, inf_x_zero;
  logic [W-1:0]         result_d;
  fp_flags_t            flags_d;

  // Normalise by one bit if needed, round, range-check, then apply specials.
  always_comb begin
    p_msb    = s2_p_q[PW-1];
    frac_raw = p_msb ? s2_p_q[PW-2 -: MAN_W] : s2_p_q[PW-3 -: MAN_W];
    guard    = p_msb ? s2_p_q[MAN_W] : s2_p_q[MAN_W-1];
    sticky   = p_msb ? (|s2_p_q[MAN_W-1:0]) : (|s2_p_q[MAN_W-2:0]);
    e_norm   = p_msb ? (s2_e_q + ONE_C) : s2_e_q;
`ifdef FP_MUL_PIPE_RNE_EN
    round_up = guard && (sticky || frac_raw[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac_raw} + {{MAN_W{1'b0}}, round_up};
    // A carry out leaves the fraction bits at zero, only the exponent bumps.
    e_fin    = frac_sum[MAN_W] ? (e_norm + ONE_C) : e_norm;

    flags_d  = '0;
    if (!e_fin[EW-1] && (e_fin >= EMAX_C)) begin
      result_d          = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.overflow  = 1'b1;
      flags_d.inexact   = 1'b1;
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      result_d          = {s2_sign_q, {(W-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else begin
      result_d          = {s2_sign_q, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
      flags_d.inexact   = guard | sticky;
    end

    nan_any    = (s2_cls_a_q == QNAN) || (s2_cls_a_q == SNAN) ||
                 (s2_cls_b_q == QNAN) || (s2_cls_b_q == SNAN);
    snan_any   = (s2_cls_a_q == SNAN) || (s2_cls_b_q == SNAN);
    inf_a      = (s2_cls_a_q == INF);
    inf_b      = (s2_cls_b_q == INF);
    zero_a     = (s2_cls_a_q == ZERO);
    zero_b     = (s2_cls_b_q == ZERO);
    inf_x_zero = (inf_a && zero_b) || (zero_a && inf_b);

    if (nan_any || inf_x_zero) begin
      result_d        = QNAN_C;
      flags_d         = '0;
      flags_d.invalid = snan_any || inf_x_zero;
    end else if (inf_a || inf_b) begin
      result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = '0;
    end else if (zero_a || zero_b) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d  = '0;
    end
  end

  logic             out_valid_q;
  logic [W-1:0]     out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  fp_flags_t        out_flags_q;

  // Output register: holds steady while the consumer stalls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_result_q <= result_d;
        out_tag_q    <= s2_tag_q;
        out_flags_q  <= flags_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_tag       = out_tag_q;
  assign out_overflow  = out_flags_q.overflow;
  assign out_underflow = out_flags_q.underflow;
  assign out_invalid   = out_flags_q.invalid;
  assign out_inexact   = out_flags_q.inexact;

endmodule : fp_mul_pipe
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Directed self-checking bench for fp_mul_pipe (single
//               precision defaults): arithmetic, rounding, range limits,
//               specials, backpressure ordering and mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_overflow, out_underflow, out_invalid, out_inexact;

  int total = 0;
  int bad   = 0;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  always #5 CLK = ~CLK;

  // Flags packed as {overflow, underflow, invalid, inexact}.
  function automatic logic [3:0] flags();
    return {out_overflow, out_underflow, out_invalid, out_inexact};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One unstalled operation: present, wait for result, check latency/value/flags/tag.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef);
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd3);
    check({name, "_result"}, 64'(out_result), 64'(er));
    check({name, "_flags"}, 64'(flags()), 64'(ef));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  logic [31:0] rne_exp;
  logic [3:0]  got_tag [4];
  logic [31:0] got_res [4];
  logic [31:0] bp_b    [4];
  int          k, acc_cnt, ngot;
  logic        acc, stale;

  initial begin
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
`ifdef FP_MUL_PIPE_RNE_EN
    rne_exp = 32'h40100002;
`else
    rne_exp = 32'h40100001;
`endif
    bp_b[0] = 32'h3F800000;
    bp_b[1] = 32'h40000000;
    bp_b[2] = 32'h40400000;
    bp_b[3] = 32'h40800000;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'(flags()), 64'd0);
    nRST = 1'b1;
    tick();

    // Arithmetic, range and special cases
    run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 4'h1, 32'h40400000, 4'b0000);
    run_op("round",     32'h3FC00001, 32'h3FC00001, 4'h2, rne_exp,       4'b0001);
    run_op("neg2x3",    32'hC0000000, 32'h40400000, 4'h3, 32'hC0C00000, 4'b0000);
    run_op("overflow",  32'h7F000000, 32'h7F000000, 4'h4, 32'h7F800000, 4'b1001);
    run_op("underflow", 32'h00800000, 32'h00800000, 4'h5, 32'h00000000, 4'b0101);
    run_op("daz",       32'h80000001, 32'h3F800000, 4'h6, 32'h80000000, 4'b0000);
    run_op("inf_x_0",   32'h7F800000, 32'h00000000, 4'h7, 32'h7FC00000, 4'b0010);
    run_op("snan",      32'h7F800001, 32'h3F800000, 4'h8, 32'h7FC00000, 4'b0010);
    run_op("qnan",      32'hFFC00000, 32'h3F800000, 4'h9, 32'h7FC00000, 4'b0000);
    run_op("neg_inf",   32'hFF800000, 32'h40000000, 4'hA, 32'hFF800000, 4'b0000);
    tick();

    // Backpressure: consumer stalled, four back-to-back offers, 1.0 x b = b
    out_ready = 1'b0;
    k = 0;
    acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a     = 32'h3F800000;
      in_b     = bp_b[k];
      in_tag   = 4'(k + 1);
      if (c == 3) check("bp_in_ready_c3", 64'(in_ready), 64'd0);
      acc = in_ready;
      tick();
      if (acc) begin
        k++;
        acc_cnt++;
      end
    end
    check("bp_accepted", 64'(acc_cnt), 64'd3);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    check("bp_hold_result", 64'(out_result), 64'h3F800000);

    // Release: remaining offer drains, results must come out 1..4 in order
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 20 && ngot < 4; c++) begin
      if (out_valid && out_ready) begin
        got_tag[ngot] = out_tag;
        got_res[ngot] = out_result;
        ngot++;
      end
      in_valid = (k < 4);
      if (k < 4) begin
        in_b   = bp_b[k];
        in_tag = 4'(k + 1);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("bp_count", 64'(ngot), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ngot) begin
        check($sformatf("bp_order_tag%0d", i), 64'(got_tag[i]), 64'(i + 1));
        check($sformatf("bp_order_res%0d", i), 64'(got_res[i]), 64'(bp_b[i]));
      end
    end
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Mid-stream reset: fill the pipe, then pull nRST between clock edges
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h3FC00000;
      in_b     = 32'h40000000;
      in_tag   = 4'(i + 11);
      tick();
    end
    in_valid = 1'b0;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_async_drop", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    nRST = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    check("mid_no_stale", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fp_mul_pipe
`default_nettype wire
